flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The module SHALL have one parameter: CNT_W, default 16, width of the taken-branch counter.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port ex_flags, input, 4 bits: adder flags from the EX stage; [3]=N, [2]=Z, [1]=V, [0]=C.
REQ-005 The module SHALL have port ex_set_flags, input, 1 bit: the EX instruction writes flags (ADDS/SUBS).
REQ-006 The module SHALL have port ex_valid, input, 1 bit: the EX instruction is real (not a bubble).
REQ-007 The module SHALL have port stall, input, 1 bit: pipeline hold; blocks all state updates.
REQ-008 The module SHALL have port flush, input, 1 bit: kills the EX instruction's flag write.
REQ-009 The module SHALL have port br_cond, input, 4 bits: condition code of the ID-stage B.cond.
REQ-010 The module SHALL have port br_is_bcond, input, 1 bit: the ID instruction is B.cond.
REQ-011 The module SHALL have port br_is_cbz, input, 1 bit: the ID instruction is CBZ.
REQ-012 The module SHALL have port br_is_cbnz, input, 1 bit: the ID instruction is CBNZ.
REQ-013 The module SHALL have port reg_zero, input, 1 bit: the CBZ/CBNZ source register equals zero.
REQ-014 The module SHALL have port flags_q, output, 4 bits: the architectural flag register.
REQ-015 The module SHALL have port flags_eff, output, 4 bits: the flags seen by the ID stage after forwarding.
REQ-016 The module SHALL have port br_taken, output, 1 bit: the combinational branch decision.
REQ-017 The module SHALL have port br_conflict, output, 1 bit: more than one branch-type input is asserted.
REQ-018 The module SHALL have port taken_cnt, output, CNT_W bits: count of taken branches.

Function
REQ-019 The module SHALL define wr_en = ex_valid & ex_set_flags & ~flush & ~stall.
REQ-020 The module SHALL load flags_q <= ex_flags on a rising clk edge when wr_en=1, and SHALL hold flags_q otherwise.
REQ-021 The module SHALL drive flags_eff = ex_flags when ex_valid & ex_set_flags & ~flush, independent of stall (EX-to-ID forwarding), and flags_q otherwise.
REQ-022 The module SHALL evaluate B.cond on flags_eff: 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E and F always true.
REQ-023 The module SHALL take CBZ when reg_zero=1 and CBNZ when reg_zero=0; neither reads the flags.
REQ-024 The module SHALL set br_conflict=1 and force br_taken=0 when two or more of br_is_bcond, br_is_cbz, br_is_cbnz are high.
REQ-025 The module SHALL hold br_taken=0 when no branch-type input is asserted.
REQ-026 The module SHALL increment taken_cnt by 1 on a rising edge when br_taken=1 and stall=0.
REQ-027 The module SHALL saturate taken_cnt at 2^CNT_W-1, with no wrap to 0.
REQ-028 The module SHALL let a flag write and a counted branch occur in the same cycle, each independently.
REQ-029 The module SHALL make stall=1 freeze flags_q and taken_cnt, while flags_eff and br_taken stay combinationally live.

Reset
REQ-030 The module SHALL set flags_q=4'b0000 and taken_cnt=0 immediately on reset=1, without waiting for clk.
REQ-031 The module SHALL ignore ex_flags and branch inputs while reset=1, and SHALL resume on the first rising edge after reset deasserts.
REQ-032 The module SHALL have no state other than flags_q and taken_cnt; combinational outputs follow their inputs even during reset.

Verification
REQ-033 The bench SHALL cover forwarding: flags_q=0000, ID has B.cond EQ, EX has SUBS with ex_flags=0100, ex_valid=1 -> br_taken=1 in the same cycle, flags_q=0100 after the edge.
REQ-034 The bench SHALL cover flush and stall: ex_flags=1000, ex_set_flags=1, flush=1 -> flags_q unchanged; repeat with stall=1 -> flags_q unchanged, flags_eff=1000.
REQ-035 The bench SHALL cover signed conditions: flags_q=1010 (N=1, V=1) -> GE=1, LT=0, GT=1, LE=0; flags_q=1110 -> GT=0, LE=1.
REQ-036 The bench SHALL cover CBZ/CBNZ and conflict: CBZ with reg_zero=1 -> br_taken=1; CBNZ with reg_zero=1 -> br_taken=0; CBZ and B.cond AL together -> br_taken=0, br_conflict=1.
REQ-037 The bench SHALL cover counter saturation: with CNT_W=4, 17 consecutive taken, unstalled branches -> taken_cnt=15 and holds.
REQ-038 The bench SHALL cover asynchronous reset: assert reset mid-cycle with flags_q=0101 and taken_cnt=7 -> both read 0 before the next clk edge.

Source files
------------

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV flag register with EX-to-ID forwarding, branch resolve and taken counter
module flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ex_flags,
    input  logic             ex_set_flags,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       br_cond,
    input  logic             br_is_bcond,
    input  logic             br_is_cbz,
    input  logic             br_is_cbnz,
    input  logic             reg_zero,
    output logic [3:0]       flags_q,
    output logic [3:0]       flags_eff,
    output logic             br_taken,
    output logic             br_conflict,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       ex_writes;
    logic       wr_en;
    logic       flag_n, flag_z, flag_v, flag_c;
    logic       cond_true;
    logic [1:0] br_type_cnt;
    logic       br_hit;

    // Forwarding ignores stall: a held EX instruction's flags are still the newest.
    assign ex_writes = ex_valid & ex_set_flags & ~flush;
    assign wr_en     = ex_writes & ~stall;
    assign flags_eff = ex_writes ? ex_flags : flags_q;

    assign flag_n = flags_eff[3];
    assign flag_z = flags_eff[2];
    assign flag_v = flags_eff[1];
    assign flag_c = flags_eff[0];

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = ~flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = ~flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = ~flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = ~flag_v;
            4'h8:    cond_true = flag_c & ~flag_z;
            4'h9:    cond_true = ~flag_c | flag_z;
            4'hA:    cond_true = (flag_n == flag_v);
            4'hB:    cond_true = (flag_n != flag_v);
            4'hC:    cond_true = ~flag_z & (flag_n == flag_v);
            4'hD:    cond_true = flag_z | (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    assign br_type_cnt = {1'b0, br_is_bcond} + {1'b0, br_is_cbz} + {1'b0, br_is_cbnz};
    assign br_conflict = (br_type_cnt >= 2'd2);

    assign br_hit = (br_is_bcond & cond_true)
                  | (br_is_cbz   & reg_zero)
                  | (br_is_cbnz  & ~reg_zero);
    assign br_taken = br_hit & ~br_conflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (wr_en) begin
            flags_q <= ex_flags;
        end
    end

    // Counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
        end else if (br_taken && !stall && taken_cnt != CNT_MAX) begin
            taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed scoreboard bench for flag_unit
module tb_flag_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       ex_flags;
    logic             ex_set_flags;
    logic             ex_valid;
    logic             stall;
    logic             flush;
    logic [3:0]       br_cond;
    logic             br_is_bcond;
    logic             br_is_cbz;
    logic             br_is_cbnz;
    logic             reg_zero;
    logic [3:0]       flags_q;
    logic [3:0]       flags_eff;
    logic             br_taken;
    logic             br_conflict;
    logic [CNT_W-1:0] taken_cnt;

    flag_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_flags    (ex_flags),
        .ex_set_flags(ex_set_flags),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .flush       (flush),
        .br_cond     (br_cond),
        .br_is_bcond (br_is_bcond),
        .br_is_cbz   (br_is_cbz),
        .br_is_cbnz  (br_is_cbnz),
        .reg_zero    (reg_zero),
        .flags_q     (flags_q),
        .flags_eff   (flags_eff),
        .br_taken    (br_taken),
        .br_conflict (br_conflict),
        .taken_cnt   (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_val(input string tag, input logic [15:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic chk(input logic [15:0] obs);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic idle();
        ex_flags     = 4'b0000;
        ex_set_flags = 1'b0;
        ex_valid     = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        br_cond      = 4'h0;
        br_is_bcond  = 1'b0;
        br_is_cbz    = 1'b0;
        br_is_cbnz   = 1'b0;
        reg_zero     = 1'b0;
    endtask

    task automatic edge_then_idle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_flags(input logic [3:0] f);
        ex_flags     = f;
        ex_set_flags = 1'b1;
        ex_valid     = 1'b1;
        edge_then_idle();
    endtask

    task automatic check_cond(input string tag, input logic [3:0] cc, input logic exp);
        br_is_bcond = 1'b1;
        br_cond     = cc;
        #1;
        expect_val(tag, {15'd0, exp});
        chk({15'd0, br_taken});
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2;
        expect_val("reset_flags_q", 16'h0);
        chk({12'd0, flags_q});
        expect_val("reset_taken_cnt", 16'h0);
        chk({12'd0, taken_cnt});
        expect_val("no_branch_taken", 16'h0);
        chk({15'd0, br_taken});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Forwarding: SUBS result reaches B.EQ in ID the same cycle.
        br_is_bcond  = 1'b1;
        br_cond      = 4'h0;
        ex_flags     = 4'b0100;
        ex_set_flags = 1'b1;
        ex_valid     = 1'b1;
        #1;
        expect_val("fwd_br_taken", 16'h1);
        chk({15'd0, br_taken});
        expect_val("fwd_flags_eff", 16'h4);
        chk({12'd0, flags_eff});
        expect_val("fwd_flags_q_before", 16'h0);
        chk({12'd0, flags_q});
        edge_then_idle();
        expect_val("fwd_flags_q_after", 16'h4);
        chk({12'd0, flags_q});
        expect_val("fwd_taken_cnt", 16'h1);
        chk({12'd0, taken_cnt});

        // Flush kills the write and the forward.
        ex_flags     = 4'b1000;
        ex_set_flags = 1'b1;
        ex_valid     = 1'b1;
        flush        = 1'b1;
        #1;
        expect_val("flush_flags_eff", 16'h4);
        chk({12'd0, flags_eff});
        edge_then_idle();
        expect_val("flush_flags_q", 16'h4);
        chk({12'd0, flags_q});

        // Stall blocks the write but forwarding and branch stay live.
        ex_flags     = 4'b1000;
        ex_set_flags = 1'b1;
        ex_valid     = 1'b1;
        stall        = 1'b1;
        br_is_bcond  = 1'b1;
        br_cond      = 4'h4;
        #1;
        expect_val("stall_flags_eff", 16'h8);
        chk({12'd0, flags_eff});
        expect_val("stall_br_taken_mi", 16'h1);
        chk({15'd0, br_taken});
        edge_then_idle();
        expect_val("stall_flags_q", 16'h4);
        chk({12'd0, flags_q});
        expect_val("stall_taken_cnt", 16'h1);
        chk({12'd0, taken_cnt});

        // Signed conditions, stalled so the counter does not move.
        load_flags(4'b1010);
        expect_val("load_1010", 16'hA);
        chk({12'd0, flags_q});
        stall = 1'b1;
        check_cond("ge_1010", 4'hA, 1'b1);
        check_cond("lt_1010", 4'hB, 1'b0);
        check_cond("gt_1010", 4'hC, 1'b1);
        check_cond("le_1010", 4'hD, 1'b0);
        check_cond("hi_1010", 4'h8, 1'b0);
        idle();
        load_flags(4'b1110);
        stall = 1'b1;
        check_cond("gt_1110", 4'hC, 1'b0);
        check_cond("le_1110", 4'hD, 1'b1);
        check_cond("ls_1110", 4'h9, 1'b1);
        check_cond("vc_1110", 4'h7, 1'b0);

        // CBZ / CBNZ / conflict.
        idle();
        stall     = 1'b1;
        br_is_cbz = 1'b1;
        reg_zero  = 1'b1;
        #1;
        expect_val("cbz_zero", 16'h1);
        chk({15'd0, br_taken});
        br_is_cbz  = 1'b0;
        br_is_cbnz = 1'b1;
        #1;
        expect_val("cbnz_zero", 16'h0);
        chk({15'd0, br_taken});
        reg_zero = 1'b0;
        #1;
        expect_val("cbnz_nonzero", 16'h1);
        chk({15'd0, br_taken});
        br_is_cbnz  = 1'b0;
        br_is_cbz   = 1'b1;
        reg_zero    = 1'b1;
        br_is_bcond = 1'b1;
        br_cond     = 4'hE;
        #1;
        expect_val("conflict_taken", 16'h0);
        chk({15'd0, br_taken});
        expect_val("conflict_flag", 16'h1);
        chk({15'd0, br_conflict});
        br_is_cbz = 1'b0;
        #1;
        expect_val("al_no_conflict", 16'h0);
        chk({15'd0, br_conflict});
        idle();

        // Saturation from a fresh counter.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        br_is_bcond = 1'b1;
        br_cond     = 4'hF;
        for (int i = 0; i < 15; i++) @(posedge clk);
        #1;
        expect_val("cnt_at_15", 16'hF);
        chk({12'd0, taken_cnt});
        for (int i = 0; i < 2; i++) @(posedge clk);
        #1;
        expect_val("cnt_sat_17", 16'hF);
        chk({12'd0, taken_cnt});
        @(posedge clk);
        #1;
        expect_val("cnt_sat_hold", 16'hF);
        chk({12'd0, taken_cnt});
        idle();

        // Async reset mid-cycle with flags_q=0101, taken_cnt=7.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        ex_flags     = 4'b0101;
        ex_set_flags = 1'b1;
        ex_valid     = 1'b1;
        br_is_bcond  = 1'b1;
        br_cond      = 4'hE;
        @(posedge clk);
        #1;
        ex_set_flags = 1'b0;
        ex_valid     = 1'b0;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        idle();
        expect_val("pre_reset_flags_q", 16'h5);
        chk({12'd0, flags_q});
        expect_val("pre_reset_cnt", 16'h7);
        chk({12'd0, taken_cnt});
        #2;
        reset     = 1'b1;
        br_is_cbz = 1'b1;
        reg_zero  = 1'b1;
        #1;
        expect_val("async_flags_q", 16'h0);
        chk({12'd0, flags_q});
        expect_val("async_cnt", 16'h0);
        chk({12'd0, taken_cnt});
        expect_val("reset_comb_live", 16'h1);
        chk({15'd0, br_taken});
        @(posedge clk);
        #1;
        expect_val("reset_holds_cnt", 16'h0);
        chk({12'd0, taken_cnt});
        @(negedge clk);
        reset = 1'b0;
        idle();
        ex_flags     = 4'b0011;
        ex_set_flags = 1'b1;
        ex_valid     = 1'b1;
        edge_then_idle();
        expect_val("resume_flags_q", 16'h3);
        chk({12'd0, flags_q});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
